e203_dma_icb_arb: RTL

- 2:1 ICB arbiter that merges the core's system-memory ICB master (m0) and the DMA data-mover ICB master (m1) onto one ICB slave port (s) toward shared SRAM/peripheral fabric.
- Sits directly downstream of the DMA master port.
- Routes each response back to the master that issued the command, using an in-order outstanding-ID FIFO.
- Guarantees ICB command stability: once granted, a master is held until its command handshakes.

---
 rtl/e203_dma_icb_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/e203_dma_icb_arb.sv
// 2:1 ICB arbiter merging the core (m0) and DMA (m1) masters onto one slave port,
// with in-order response routing. Define E203_DMA_ARB_RR_EN for round-robin, else m0 has fixed priority.
module e203_dma_icb_arb #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_icb_cmd_valid,
   output logic            m0_icb_cmd_ready,
   input  logic [AW-1:0]   m0_icb_cmd_addr,
   input  logic            m0_icb_cmd_read,
   input  logic [DW-1:0]   m0_icb_cmd_wdata,
   input  logic [DW/8-1:0] m0_icb_cmd_wmask,
   output logic            m0_icb_rsp_valid,
   input  logic            m0_icb_rsp_ready,
   output logic            m0_icb_rsp_err,
   output logic [DW-1:0]   m0_icb_rsp_rdata,
   input  logic            m1_icb_cmd_valid,
   output logic            m1_icb_cmd_ready,
   input  logic [AW-1:0]   m1_icb_cmd_addr,
   input  logic            m1_icb_cmd_read,
   input  logic [DW-1:0]   m1_icb_cmd_wdata,
   input  logic [DW/8-1:0] m1_icb_cmd_wmask,
   output logic            m1_icb_rsp_valid,
   input  logic            m1_icb_rsp_ready,
   output logic            m1_icb_rsp_err,
   output logic [DW-1:0]   m1_icb_rsp_rdata,
   output logic            s_icb_cmd_valid,
   input  logic            s_icb_cmd_ready,
   output logic [AW-1:0]   s_icb_cmd_addr,
   output logic            s_icb_cmd_read,
   output logic [DW-1:0]   s_icb_cmd_wdata,
   output logic [DW/8-1:0] s_icb_cmd_wmask,
   input  logic            s_icb_rsp_valid,
   output logic            s_icb_rsp_ready,
   input  logic            s_icb_rsp_err,
   input  logic [DW-1:0]   s_icb_rsp_rdata
);

   localparam int PW = $clog2(OUTS_DEPTH) + 1;
   localparam logic [PW-1:0] IDX_MASK = PW'(OUTS_DEPTH - 1);

   logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
   logic [PW-1:0]         wr_idx_s, rd_idx_s;
   logic [OUTS_DEPTH-1:0] id_mem_r, wr_oh_s, rd_oh_s;
   logic                  lock_r, lock_id_r, stray_rsp_r;
   logic                  gnt_s, gnt_vld_s, rr_sel_s, head_s;
   logic                  fifo_full_s, fifo_empty_s, cmd_hs_s, push_s, pop_s;

`ifdef E203_DMA_ARB_RR_EN
   logic rr_ptr_r;

   // Round-robin pointer: after every issued command, favour the other master.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= 1'b0;
      end else if (cmd_hs_s) begin
         rr_ptr_r <= ~gnt_s;
      end
   end
   assign rr_sel_s = rr_ptr_r;
`else
   assign rr_sel_s = 1'b0;
`endif

   // Grant select: a lock pins the grant so a pending command cannot be swapped out.
   always_comb begin
      gnt_s = 1'b0;
      if (lock_r) begin
         gnt_s = lock_id_r;
      end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
         gnt_s = rr_sel_s;
      end else if (m1_icb_cmd_valid) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   assign gnt_vld_s    = gnt_s ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign wr_idx_s     = wr_ptr_r & IDX_MASK;
   assign rd_idx_s     = rd_ptr_r & IDX_MASK;
   assign wr_oh_s      = OUTS_DEPTH'(1'b1) << wr_idx_s;
   assign rd_oh_s      = OUTS_DEPTH'(1'b1) << rd_idx_s;
   assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
   assign fifo_full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_idx_s == rd_idx_s);
   assign head_s       = |(id_mem_r & rd_oh_s);

   assign s_icb_cmd_valid  = gnt_vld_s & ~fifo_full_s;
   assign s_icb_cmd_addr   = gnt_s ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign s_icb_cmd_read   = gnt_s ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign s_icb_cmd_wdata  = gnt_s ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign s_icb_cmd_wmask  = gnt_s ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
   assign m0_icb_cmd_ready = ~gnt_s & s_icb_cmd_ready & ~fifo_full_s;
   assign m1_icb_cmd_ready =  gnt_s & s_icb_cmd_ready & ~fifo_full_s;
   assign cmd_hs_s         = s_icb_cmd_valid & s_icb_cmd_ready;
   assign push_s           = cmd_hs_s;

   // Responses with no outstanding entry are swallowed (ready held high).
   assign m0_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty_s & ~head_s;
   assign m1_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty_s &  head_s;
   assign m0_icb_rsp_err   = m0_icb_rsp_valid & s_icb_rsp_err;
   assign m1_icb_rsp_err   = m1_icb_rsp_valid & s_icb_rsp_err;
   assign m0_icb_rsp_rdata = {DW{m0_icb_rsp_valid}} & s_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = {DW{m1_icb_rsp_valid}} & s_icb_rsp_rdata;
   assign s_icb_rsp_ready  = fifo_empty_s ? 1'b1 : (head_s ? m1_icb_rsp_ready : m0_icb_rsp_ready);
   assign pop_s            = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty_s;

   // Outstanding-ID FIFO, grant lock and stray-response flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         id_mem_r    <= {OUTS_DEPTH{1'b0}};
         lock_r      <= 1'b0;
         lock_id_r   <= 1'b0;
         stray_rsp_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
            id_mem_r <= (id_mem_r & ~wr_oh_s) | ({OUTS_DEPTH{gnt_s}} & wr_oh_s);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         lock_r      <= gnt_vld_s & ~cmd_hs_s;
         lock_id_r   <= gnt_s;
         stray_rsp_r <= stray_rsp_r | (s_icb_rsp_valid & fifo_empty_s);
      end
   end

endmodule
